// File: rtl/mem_wb_pkg.sv
// Shared types, constants and helpers for the MEM->WB pipeline stage.
package mem_wb_pkg;

    localparam int MAX_LANES = 4;
    localparam int WB_DATA_W = 32;
    localparam int WB_REG_AW = 5;

    // Load/store tag carried with each lane.
    localparam logic [1:0] LS_NONE  = 2'b00;
    localparam logic [1:0] LS_LOAD  = 2'b01;
    localparam logic [1:0] LS_STORE = 2'b10;

    // One lane's writeback payload at the default widths.
    typedef struct packed {
        logic                 reg_we;
        logic [WB_REG_AW-1:0] reg_waddr;
        logic [WB_DATA_W-1:0] memout;
        logic [WB_DATA_W-1:0] aluout;
        logic [1:0]           ls;
        logic [1:0]           hilo_we;
        logic [63:0]          hilo_data;
        logic                 cp0_we;
        logic [7:0]           cp0_addr;
        logic [31:0]          pc;
    } wb_lane_t;

    // Lane index width; a single-lane build still carries a 1-bit index.
    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Width of a whole bundle flattened as {lane_valid, payload fields}.
    // Fixed per-lane bits: valid, reg_we, ls, hilo_we, hilo_data, cp0_we, cp0_addr, pc.
    function automatic int bundle_w(input int lanes, input int data_w, input int reg_aw);
        return lanes * (2 * data_w + reg_aw + 111);
    endfunction

    function automatic logic [2:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/mem_wb_stage_n_if.sv
// MEM->WB bundle interface: input bundle from MEM, exception/flush, output bundle to WB.
interface mem_wb_stage_n_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    import mem_wb_pkg::*;

    localparam int LW = lane_w(LANES);

    logic                       in_valid;
    logic                       in_ready;
    logic [LANES-1:0]           in_lane_valid;
    logic [LANES-1:0]           in_reg_we;
    logic [LANES*REG_AW-1:0]    in_reg_waddr;
    logic [LANES*DATA_W-1:0]    in_memout;
    logic [LANES*DATA_W-1:0]    in_aluout;
    logic [LANES*2-1:0]         in_ls;
    logic [LANES*2-1:0]         in_hilo_we;
    logic [LANES*64-1:0]        in_hilo_data;
    logic [LANES-1:0]           in_cp0_we;
    logic [LANES*8-1:0]         in_cp0_addr;
    logic [LANES*32-1:0]        in_pc;
    logic                       exc_valid;
    logic [LW-1:0]              exc_lane;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES-1:0]           out_lane_valid;
    logic [LANES-1:0]           out_reg_we;
    logic [LANES*REG_AW-1:0]    out_reg_waddr;
    logic [LANES*DATA_W-1:0]    out_memout;
    logic [LANES*DATA_W-1:0]    out_aluout;
    logic [LANES*2-1:0]         out_ls;
    logic [LANES*2-1:0]         out_hilo_we;
    logic [LANES*64-1:0]        out_hilo_data;
    logic [LANES-1:0]           out_cp0_we;
    logic [LANES*8-1:0]         out_cp0_addr;
    logic [LANES*32-1:0]        out_pc;

    modport master (
        output in_valid, in_lane_valid, in_reg_we, in_reg_waddr, in_memout, in_aluout,
               in_ls, in_hilo_we, in_hilo_data, in_cp0_we, in_cp0_addr, in_pc,
               exc_valid, exc_lane, flush, out_ready,
        input  in_ready, out_valid, out_lane_valid, out_reg_we, out_reg_waddr, out_memout,
               out_aluout, out_ls, out_hilo_we, out_hilo_data, out_cp0_we, out_cp0_addr, out_pc
    );

    modport slave (
        input  in_valid, in_lane_valid, in_reg_we, in_reg_waddr, in_memout, in_aluout,
               in_ls, in_hilo_we, in_hilo_data, in_cp0_we, in_cp0_addr, in_pc,
               exc_valid, exc_lane, flush, out_ready,
        output in_ready, out_valid, out_lane_valid, out_reg_we, out_reg_waddr, out_memout,
               out_aluout, out_ls, out_hilo_we, out_hilo_data, out_cp0_we, out_cp0_addr, out_pc
    );

endinterface

// File: rtl/mem_wb_lane_mask.sv
// Age-ordered exception kill and enable gating for one incoming bundle.
// Lanes at or beyond the excepting lane are killed; an out-of-range index kills none.
module mem_wb_lane_mask #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int LW     = 1,
    parameter int BW     = 1
) (
    input  logic [LANES-1:0]        i_lane_valid,
    input  logic [LANES-1:0]        i_reg_we,
    input  logic [LANES*REG_AW-1:0] i_reg_waddr,
    input  logic [LANES*DATA_W-1:0] i_memout,
    input  logic [LANES*DATA_W-1:0] i_aluout,
    input  logic [LANES*2-1:0]      i_ls,
    input  logic [LANES*2-1:0]      i_hilo_we,
    input  logic [LANES*64-1:0]     i_hilo_data,
    input  logic [LANES-1:0]        i_cp0_we,
    input  logic [LANES*8-1:0]      i_cp0_addr,
    input  logic [LANES*32-1:0]     i_pc,
    input  logic                    i_exc_valid,
    input  logic [LW-1:0]           i_exc_lane,
    output logic [BW-1:0]           o_bundle,
    output logic                    o_any
);

    logic [LANES-1:0]        w_keep;
    logic [LANES-1:0]        w_lv;
    logic [LANES-1:0]        w_reg_we;
    logic [LANES*REG_AW-1:0] w_reg_waddr;
    logic [LANES*DATA_W-1:0] w_memout;
    logic [LANES*DATA_W-1:0] w_aluout;
    logic [LANES*2-1:0]      w_ls;
    logic [LANES*2-1:0]      w_hilo_we;
    logic [LANES*64-1:0]     w_hilo_data;
    logic [LANES-1:0]        w_cp0_we;
    logic [LANES*8-1:0]      w_cp0_addr;
    logic [LANES*32-1:0]     w_pc;

    // Per lane: compute keep bit, gate valid and enables, zero the data of killed lanes.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        w_keep      = '0;
        w_lv        = '0;
        w_reg_we    = '0;
        w_reg_waddr = '0;
        w_memout    = '0;
        w_aluout    = '0;
        w_ls        = '0;
        w_hilo_we   = '0;
        w_hilo_data = '0;
        w_cp0_we    = '0;
        w_cp0_addr  = '0;
        w_pc        = '0;
        for (int i = 0; i < LANES; i++) begin
            w_keep[i]                 = !(i_exc_valid && (i >= int'(i_exc_lane)));
            w_lv[i]                   = i_lane_valid[i] & w_keep[i];
            w_reg_we[i]               = i_reg_we[i] & w_lv[i];
            w_hilo_we[2*i +: 2]       = i_hilo_we[2*i +: 2] & {2{w_lv[i]}};
            w_cp0_we[i]               = i_cp0_we[i] & w_lv[i];
            if (w_keep[i]) begin
                w_reg_waddr[i*REG_AW +: REG_AW] = i_reg_waddr[i*REG_AW +: REG_AW];
                w_memout[i*DATA_W +: DATA_W]    = i_memout[i*DATA_W +: DATA_W];
                w_aluout[i*DATA_W +: DATA_W]    = i_aluout[i*DATA_W +: DATA_W];
                w_ls[2*i +: 2]                  = i_ls[2*i +: 2];
                w_hilo_data[64*i +: 64]         = i_hilo_data[64*i +: 64];
                w_cp0_addr[8*i +: 8]            = i_cp0_addr[8*i +: 8];
                w_pc[32*i +: 32]                = i_pc[32*i +: 32];
            end
        end
    end

    assign o_any    = |w_lv;
    assign o_bundle = {w_lv, w_reg_we, w_reg_waddr, w_memout, w_aluout, w_ls,
                       w_hilo_we, w_hilo_data, w_cp0_we, w_cp0_addr, w_pc};

endmodule

// File: rtl/mem_wb_stage_n.sv
// N-issue MEM->WB pipeline register: main entry M drives WB, skid entry S absorbs
// one bundle while WB stalls. Flush drops both entries; retired_cnt counts committed lanes.
module mem_wb_stage_n
    import mem_wb_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_wb_stage_n_if.slave   bus,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam int LW = lane_w(LANES);
    localparam int BW = bundle_w(LANES, DATA_W, REG_AW);

    logic [BW-1:0]    w_bundle;
    logic             w_any;
    logic             w_accept;
    logic             w_store;
    logic             w_drain;
    logic             w_retire;
    logic             w_m_valid_nxt;
    logic             w_s_valid_nxt;
    logic             w_m_from_s;
    logic             w_m_from_in;
    logic             w_s_from_in;

    logic             r_m_valid;
    logic             r_s_valid;
    logic             r_in_ready;
    logic [BW-1:0]    r_m_data;
    logic [BW-1:0]    r_s_data;
    logic [CNT_W-1:0] r_retired;

    mem_wb_lane_mask #(
        .LANES (LANES),
        .DATA_W(DATA_W),
        .REG_AW(REG_AW),
        .LW    (LW),
        .BW    (BW)
    ) u_lane_mask (
        .i_lane_valid(bus.in_lane_valid),
        .i_reg_we    (bus.in_reg_we),
        .i_reg_waddr (bus.in_reg_waddr),
        .i_memout    (bus.in_memout),
        .i_aluout    (bus.in_aluout),
        .i_ls        (bus.in_ls),
        .i_hilo_we   (bus.in_hilo_we),
        .i_hilo_data (bus.in_hilo_data),
        .i_cp0_we    (bus.in_cp0_we),
        .i_cp0_addr  (bus.in_cp0_addr),
        .i_pc        (bus.in_pc),
        .i_exc_valid (bus.exc_valid),
        .i_exc_lane  (bus.exc_lane),
        .o_bundle    (w_bundle),
        .o_any       (w_any)
    );

    // An all-killed bundle is still accepted but never occupies an entry.
    assign w_accept = bus.in_valid && r_in_ready && !bus.flush;
    assign w_store  = w_accept && w_any;
    assign w_drain  = r_m_valid && bus.out_ready;
    assign w_retire = w_drain && !bus.flush;

    // Next occupancy of M/S and which source loads each entry; flush wins over everything.
    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_s_valid_nxt = r_s_valid;
        w_m_from_s    = 1'b0;
        w_m_from_in   = 1'b0;
        w_s_from_in   = 1'b0;
        if (bus.flush) begin
            w_m_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
        end else if (!r_m_valid || w_drain) begin
            if (r_s_valid) begin
                w_m_from_s    = 1'b1;
                w_m_valid_nxt = 1'b1;
                w_s_from_in   = w_store;
                w_s_valid_nxt = w_store;
            end else begin
                w_m_from_in   = w_store;
                w_m_valid_nxt = w_store;
            end
        end else if (w_store) begin
            w_s_from_in   = 1'b1;
            w_s_valid_nxt = 1'b1;
        end
    end

    // Entry registers, registered in_ready and the retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: payload registers are cleared too, so the out_* ports read zero in reset.
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b0;
            r_m_data   <= '0;
            r_s_data   <= '0;
            r_retired  <= '0;
        end else begin
            // NOTE: non-blocking so M can load the old S while S loads new data in one edge.
            r_m_valid  <= w_m_valid_nxt;
            r_s_valid  <= w_s_valid_nxt;
            r_in_ready <= !w_s_valid_nxt;
            if (w_m_from_s) begin
                r_m_data <= r_s_data;
            end else if (w_m_from_in) begin
                r_m_data <= w_bundle;
            end
            if (w_s_from_in) begin
                r_s_data <= w_bundle;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(popcount(MAX_LANES'(bus.out_lane_valid)));
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_m_valid;
    assign {bus.out_lane_valid, bus.out_reg_we, bus.out_reg_waddr, bus.out_memout,
            bus.out_aluout, bus.out_ls, bus.out_hilo_we, bus.out_hilo_data,
            bus.out_cp0_we, bus.out_cp0_addr, bus.out_pc} = r_m_data;
    assign retired_cnt   = r_retired;

endmodule
